// File: rtl/tao_ifu_pkg.sv
// Shared definitions for the tao instruction fetch unit: bus width, reset PC,
// fetch FSM state encoding and the PC alignment test.
package tao_ifu_pkg;

  localparam int          TAO_SIZE_BUS = 32;
  localparam logic [31:0] TAO_RESET_PC = 32'h8000_0000;

  typedef enum logic [1:0] {
    TAO_IFU_REQ  = 2'd0,
    TAO_IFU_WAIT = 2'd1,
    TAO_IFU_HOLD = 2'd2,
    TAO_IFU_ERR  = 2'd3
  } ifu_state_e;

  // Instructions are word aligned; any set low bit in a target PC is a fault.
  function automatic logic is_misaligned(input logic [1:0] pc_lsb);
    return pc_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/tao_ifu.sv
// Instruction fetch unit: one outstanding imem read per instruction, presents
// the word to the core and advances the PC on the core's commit.
module tao_ifu
  import tao_ifu_pkg::*;
#(
  parameter int                ADDR_W   = TAO_SIZE_BUS,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(TAO_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit,
  input  logic [ADDR_W-1:0] dnpc,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic              fetch_err,
  output logic [31:0]       fetch_cnt,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              imem_rsp_err
);

  ifu_state_e        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_inst;
  logic              r_inst_valid;
  logic              r_fetch_err;
  logic [31:0]       r_fetch_cnt;
  logic              r_started;
  logic              w_req_valid;

  // r_started keeps the request low during the first cycle out of reset so
  // the first fetch appears one cycle after reset is released.
  assign w_req_valid = (r_state == TAO_IFU_REQ) && r_started;

  // NOTE: all state below uses non-blocking assignments so every flop sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= TAO_IFU_REQ;
      r_pc         <= RESET_PC;
      r_inst       <= 32'h0;
      r_inst_valid <= 1'b0;
      r_fetch_err  <= 1'b0;
      r_fetch_cnt  <= 32'h0;
      r_started    <= 1'b0;
    end else begin
      r_started <= 1'b1;
      case (r_state)
        TAO_IFU_REQ: begin
          if (w_req_valid && imem_req_ready) r_state <= TAO_IFU_WAIT;
        end
        TAO_IFU_WAIT: begin
          if (imem_rsp_valid) begin
            if (imem_rsp_err) begin
              r_fetch_err <= 1'b1;
              r_state     <= TAO_IFU_ERR;
            end else begin
              r_inst       <= imem_rsp_data;
              r_inst_valid <= 1'b1;
              r_fetch_cnt  <= r_fetch_cnt + 32'd1;
              r_state      <= TAO_IFU_HOLD;
            end
          end
        end
        TAO_IFU_HOLD: begin
          if (commit) begin
            r_inst_valid <= 1'b0;
            if (is_misaligned(dnpc[1:0])) begin
              r_fetch_err <= 1'b1;
              r_state     <= TAO_IFU_ERR;
            end else begin
              r_pc    <= dnpc;
              r_state <= TAO_IFU_REQ;
            end
          end
        end
        TAO_IFU_ERR: ;
        default: r_state <= TAO_IFU_ERR;
      endcase
    end
  end

  assign pc             = r_pc;
  assign inst           = r_inst;
  assign inst_valid     = r_inst_valid;
  assign fetch_err      = r_fetch_err;
  assign fetch_cnt      = r_fetch_cnt;
  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = r_pc;

endmodule

// File: tb/tb_tao_ifu.sv
// Directed bench for tao_ifu: inputs driven and outputs checked on the falling
// edge, with hand-computed expectations at every step.
module tb_tao_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit;
  logic [31:0] dnpc;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic        fetch_err;
  logic [31:0] fetch_cnt;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  always #5 clk = ~clk;

  tao_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .commit         (commit),
    .dnpc           (dnpc),
    .pc             (pc),
    .inst           (inst),
    .inst_valid     (inst_valid),
    .fetch_err      (fetch_err),
    .fetch_cnt      (fetch_cnt),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one full cycle; the caller lands just after the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; commit = 1'b0; dnpc = '0; imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; imem_rsp_err = 1'b0;
    step(); step();

    // Reset state
    check("rst_pc",        pc, RST_PC);
    check("rst_inst",      inst, 32'h0);
    check("rst_valid",     32'(inst_valid), 32'h0);
    check("rst_err",       32'(fetch_err), 32'h0);
    check("rst_cnt",       fetch_cnt, 32'h0);
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);

    // First fetch with zero-wait memory
    rst = 1'b0;
    check("c0_req_valid", 32'(imem_req_valid), 32'h0);
    step();
    check("c1_req_valid", 32'(imem_req_valid), 32'h1);
    check("c1_req_addr",  imem_req_addr, 32'h8000_0000);
    step();
    check("c2_wait_req", 32'(imem_req_valid), 32'h0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
    step();
    imem_rsp_valid = 1'b0;
    check("c3_valid", 32'(inst_valid), 32'h1);
    check("c3_inst",  inst, 32'h0000_0013);
    check("c3_cnt",   fetch_cnt, 32'd1);
    check("c3_pc",    pc, 32'h8000_0000);

    // Commit to +4; spurious commits in REQ and WAIT must be ignored
    commit = 1'b1; dnpc = 32'h8000_0004;
    step();
    dnpc = 32'h9000_0000;
    check("seq_req_valid", 32'(inst_valid), 32'h0);
    check("seq_req",       32'(imem_req_valid), 32'h1);
    check("seq_req_addr",  imem_req_addr, 32'h8000_0004);
    step();
    dnpc = 32'hA000_0000;
    check("seq_wait_valid", 32'(inst_valid), 32'h0);
    check("seq_wait_pc",    pc, 32'h8000_0004);
    check("seq_wait_req",   32'(imem_req_valid), 32'h0);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0010_0093;
    step();
    commit = 1'b0; imem_rsp_valid = 1'b0;
    check("seq_hold_valid", 32'(inst_valid), 32'h1);
    check("seq_hold_inst",  inst, 32'h0010_0093);
    check("seq_hold_pc",    pc, 32'h8000_0004);
    check("seq_hold_cnt",   fetch_cnt, 32'd2);

    // Stray response in HOLD must not modify inst
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    check("hold_stray_inst",  inst, 32'h0010_0093);
    check("hold_stray_valid", 32'(inst_valid), 32'h1);
    check("hold_stray_cnt",   fetch_cnt, 32'd2);

    // Back-pressure: ready low for 5 cycles, response 4 cycles after accept
    commit = 1'b1; dnpc = 32'h8000_0008; imem_req_ready = 1'b0;
    step();
    commit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_req",   32'(imem_req_valid), 32'h1);
      check("bp_addr",  imem_req_addr, 32'h8000_0008);
      check("bp_valid", 32'(inst_valid), 32'h0);
      if (i == 4) imem_req_ready = 1'b1;
      step();
    end
    for (int i = 0; i < 4; i++) begin
      check("dly_req",   32'(imem_req_valid), 32'h0);
      check("dly_valid", 32'(inst_valid), 32'h0);
      step();
    end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0020_0113;
    step();
    imem_rsp_valid = 1'b0;
    check("bp_hold_valid", 32'(inst_valid), 32'h1);
    check("bp_hold_inst",  inst, 32'h0020_0113);
    check("bp_hold_cnt",   fetch_cnt, 32'd3);
    step();
    check("bp_hold_stay", 32'(inst_valid), 32'h1);
    check("bp_hold_cnt2", fetch_cnt, 32'd3);

    // Reset in WAIT, then a stray response on the first post-reset cycle
    commit = 1'b1; dnpc = 32'h8000_000C;
    step();
    commit = 1'b0;
    step();
    check("wr_in_wait", 32'(imem_req_valid), 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBADB_AD00;
    check("wr_pc",    pc, RST_PC);
    check("wr_inst",  inst, 32'h0);
    check("wr_valid", 32'(inst_valid), 32'h0);
    check("wr_cnt",   fetch_cnt, 32'h0);
    step();
    imem_rsp_valid = 1'b0;
    check("wr_stray_inst", inst, 32'h0);
    check("wr_stray_vld",  32'(inst_valid), 32'h0);
    check("wr_req",        32'(imem_req_valid), 32'h1);
    check("wr_req_addr",   imem_req_addr, RST_PC);
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0013;
    step();
    imem_rsp_valid = 1'b0;
    check("wr_fetch_valid", 32'(inst_valid), 32'h1);
    check("wr_fetch_cnt",   fetch_cnt, 32'd1);

    // Misaligned dnpc: sticky error, no requests, pc retained
    commit = 1'b1; dnpc = 32'h8000_0006;
    step();
    commit = 1'b0;
    check("mis_err",   32'(fetch_err), 32'h1);
    check("mis_valid", 32'(inst_valid), 32'h0);
    check("mis_pc",    pc, 32'h8000_0000);
    check("mis_req",   32'(imem_req_valid), 32'h0);
    commit = 1'b1; dnpc = 32'h8000_0010; imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_1111;
    step(); step(); step();
    commit = 1'b0; imem_rsp_valid = 1'b0;
    check("err_hold_err",  32'(fetch_err), 32'h1);
    check("err_hold_pc",   pc, 32'h8000_0000);
    check("err_hold_req",  32'(imem_req_valid), 32'h0);
    check("err_hold_inst", inst, 32'h0000_0013);
    check("err_hold_cnt",  fetch_cnt, 32'd1);

    // Memory access fault on the response
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rerst_err", 32'(fetch_err), 32'h0);
    step();
    check("rsperr_req", 32'(imem_req_valid), 32'h1);
    step();
    imem_rsp_valid = 1'b1; imem_rsp_err = 1'b1; imem_rsp_data = 32'h0000_0013;
    step();
    imem_rsp_valid = 1'b0; imem_rsp_err = 1'b0;
    check("rsperr_err",   32'(fetch_err), 32'h1);
    check("rsperr_valid", 32'(inst_valid), 32'h0);
    check("rsperr_cnt",   fetch_cnt, 32'h0);
    check("rsperr_req",   32'(imem_req_valid), 32'h0);
    check("rsperr_pc",    pc, RST_PC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
